// File: rtl/cache_line_refill.sv
// Cache miss handler: optional word-by-word writeback of a dirty victim line,
// then a word-by-word fill of the missing line, finishing with a done pulse.
package cache_pkg;
    typedef enum logic {LW = 1'b0, SW = 1'b1} lsu_ops;
endpackage

module cache_line_refill
    import cache_pkg::*;
#(
    parameter int data           = 32,
    parameter int words_per_line = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           miss_req,
    input  logic [31:0]                    miss_addr,
    input  logic                           victim_dirty,
    input  logic [31:0]                    victim_addr,
    input  logic [data*words_per_line-1:0] victim_line,
    output logic                           busy,
    output logic                           done,
    output logic [data*words_per_line-1:0] fill_line,
    output logic                           mem_req,
    output lsu_ops                         lsu_operator,
    output logic [31:0]                    address,
    output logic [data-1:0]                write_data_int,
    input  logic                           mem_ready,
    input  logic [data-1:0]                dram_data_out
);
    localparam int KW                = $clog2(words_per_line);
    localparam int LINE_W            = data * words_per_line;
    localparam logic [31:0] LINE_MASK = ~32'(words_per_line - 1);
    localparam logic [KW-1:0] K_LAST  = KW'(words_per_line - 1);

    typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL_REQ, S_FILL_CAP, S_DONE} state_t;

    state_t            state_reg, state_next;
    logic [KW-1:0]     k_reg, k_next;
    logic [31:0]       miss_line_reg, miss_line_next;
    logic [31:0]       victim_base_reg, victim_base_next;
    logic [LINE_W-1:0] victim_data_reg, victim_data_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              mem_req_reg, mem_req_next;
    lsu_ops            op_reg, op_next;
    logic [31:0]       address_reg, address_next;
    logic [data-1:0]   wdata_reg, wdata_next;
    logic [LINE_W-1:0] fill_line_reg, fill_line_next;
    logic              fill_we;
    logic              accept;
    logic [data-1:0]   victim_word [words_per_line];

    assign accept = mem_req_reg && mem_ready;

    // Line bases are stored with their low bits cleared so word k's address is base | k.
    genvar gi;
    generate
        for (gi = 0; gi < words_per_line; gi++) begin : g_words
            assign victim_word[gi] = victim_data_reg[gi*data +: data];
            assign fill_line_next[gi*data +: data] =
                (fill_we && k_reg == KW'(gi)) ? dram_data_out : fill_line_reg[gi*data +: data];
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        k_next           = k_reg;
        miss_line_next   = miss_line_reg;
        victim_base_next = victim_base_reg;
        victim_data_next = victim_data_reg;
        mem_req_next     = mem_req_reg;
        op_next          = op_reg;
        address_next     = address_reg;
        wdata_next       = wdata_reg;
        done_next        = 1'b0;
        fill_we          = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (miss_req) begin
                    miss_line_next   = miss_addr & LINE_MASK;
                    victim_base_next = victim_addr & LINE_MASK;
                    victim_data_next = victim_line;
                    k_next           = '0;
                    mem_req_next     = 1'b1;
                    if (victim_dirty) begin
                        state_next   = S_WB;
                        op_next      = SW;
                        address_next = victim_addr & LINE_MASK;
                        wdata_next   = victim_line[data-1:0];
                    end else begin
                        state_next   = S_FILL_REQ;
                        op_next      = LW;
                        address_next = miss_addr & LINE_MASK;
                    end
                end
            end
            S_WB: begin
                if (accept) begin
                    if (k_reg == K_LAST) begin
                        state_next   = S_FILL_REQ;
                        k_next       = '0;
                        op_next      = LW;
                        address_next = miss_line_reg;
                    end else begin
                        k_next       = k_reg + KW'(1);
                        address_next = victim_base_reg | 32'(k_next);
                        wdata_next   = victim_word[k_next];
                    end
                end
            end
            S_FILL_REQ: begin
                if (accept) begin
                    state_next   = S_FILL_CAP;
                    mem_req_next = 1'b0;
                end
            end
            S_FILL_CAP: begin
                fill_we = 1'b1;
                if (k_reg == K_LAST) begin
                    state_next = S_DONE;
                    done_next  = 1'b1;
                end else begin
                    state_next   = S_FILL_REQ;
                    k_next       = k_reg + KW'(1);
                    mem_req_next = 1'b1;
                    address_next = miss_line_reg | 32'(k_next);
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next   = S_IDLE;
                mem_req_next = 1'b0;
            end
        endcase
        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            k_reg           <= '0;
            miss_line_reg   <= '0;
            victim_base_reg <= '0;
            victim_data_reg <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            mem_req_reg     <= 1'b0;
            op_reg          <= LW;
            address_reg     <= '0;
            wdata_reg       <= '0;
            fill_line_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            k_reg           <= k_next;
            miss_line_reg   <= miss_line_next;
            victim_base_reg <= victim_base_next;
            victim_data_reg <= victim_data_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            mem_req_reg     <= mem_req_next;
            op_reg          <= op_next;
            address_reg     <= address_next;
            wdata_reg       <= wdata_next;
            fill_line_reg   <= fill_line_next;
        end
    end

    assign busy           = busy_reg;
    assign done           = done_reg;
    assign fill_line      = fill_line_reg;
    assign mem_req        = mem_req_reg;
    assign lsu_operator   = op_reg;
    assign address        = address_reg;
    assign write_data_int = wdata_reg;
endmodule

// File: doc/cache_line_refill.md
Name: cache_line_refill

Overview:
- Miss handler between the data-cache controller and the DRAM model.
- On a cache miss it optionally writes back a dirty victim line, word by word, using SW requests. It then fetches the missing line, word by word, using LW requests.
- It presents the assembled line to the cache array with a one-cycle done pulse.
- It is the only master of the DRAM request port (mem_req / lsu_operator / address / write_data_int).

Parameters:
- data, 32, width of one DRAM word in bits
- words_per_line, 4, words per cache line; power of two, 2..16

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- miss_req  in  1  start request; sampled only in IDLE
- miss_addr  in  32  word address of the missing line; low log2(words_per_line) bits ignored (treated as 0)
- victim_dirty  in  1  victim must be written back first
- victim_addr  in  32  word address of victim line; low bits ignored as for miss_addr
- victim_line  in  data*words_per_line  victim data; word k at bits [k*data +: data]
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse; fill_line is valid
- fill_line  out  data*words_per_line  fetched line; word k at [k*data +: data]
- mem_req  out  1  DRAM request
- lsu_operator  out  lsu_ops  LW or SW (cache_pkg)
- address  out  32  DRAM word address
- write_data_int  out  data  SW data
- mem_ready  in  1  DRAM accepts the request this cycle
- dram_data_out  in  data  DRAM read data; registered, valid the cycle after an accepted LW

Behaviour:
- Reset values: state IDLE, word counter 0, busy 0, done 0, mem_req 0, lsu_operator LW, address 0, write_data_int 0, fill_line 0.
- Latched at acceptance: miss_addr, victim_addr, victim_dirty and victim_line, all captured in the IDLE cycle where miss_req=1. Later input changes have no effect.
- A beat is accepted when mem_req && mem_ready in the same cycle.
- All outputs are registered. Word counter k is log2(words_per_line) bits wide.
- Line addressing: word k address = {line_addr[31:log2(W)], k}. No carry into the upper bits.
- States:
  - IDLE: if miss_req, latch inputs and go to WB when victim_dirty=1, else go to FILL_REQ. k=0. Otherwise stay.
  - WB:
    - Drive mem_req=1, lsu_operator=SW, address=victim word k, write_data_int=victim word k.
    - On accept: if k=W-1, go to FILL_REQ with k=0; else k+1.
    - No accept: hold all outputs.
  - FILL_REQ:
    - Drive mem_req=1, lsu_operator=LW, address=miss word k.
    - On accept go to FILL_CAP. No accept: hold.
  - FILL_CAP:
    - mem_req=0. Capture dram_data_out into fill_line word k.
    - If k=W-1 go to DONE; else k+1 and go to FILL_REQ.
  - DONE: done=1 for exactly this cycle, mem_req=0, then IDLE.
- mem_req is 0 in IDLE, FILL_CAP and DONE. This gives at most one outstanding LW, so read data is never lost.
- fill_line holds its value after done until the next fill overwrites words. Words are overwritten progressively.
- Latency with mem_ready always equal to mem_req, W=4, counted from the IDLE cycle that samples miss_req (cycle 0):
  - Clean miss: LW accepts at cycles 1, 3, 5, 7; done at cycle 9.
  - Dirty miss: SW at cycles 1–4, LW at 5, 7, 9, 11; done at cycle 13.
  - General: done = 1 + (dirty ? W : 0) + 2W cycles, plus stall cycles.
- Stalls:
  - mem_ready low while mem_req=1 stalls indefinitely with address, lsu_operator and write_data_int stable.
  - mem_ready high while mem_req=0 is ignored.
- miss_req while busy is ignored and not queued. The requester must re-assert it after done.
- miss_req in the DONE cycle is ignored. It is accepted in the following IDLE cycle if still high.
- miss_addr equal to victim_addr is legal. The fill returns the just-written data.
- rst mid-operation: next cycle state is IDLE and every output takes its reset value. No done is issued. A partial writeback is not resumed.

Test Plan:
- Clean miss, miss_addr=0x10, DRAM reset contents, mem_ready=mem_req → LW addresses 0x10, 0x11, 0x12, 0x13; done at cycle 9; fill_line words = 0xDEAD0010..0xDEAD0013; busy high for cycles 1–9.
- Dirty miss, victim_addr=0x20, victim_line={0xA3,0xA2,0xA1,0xA0}, miss_addr=0x20 → SW 0x20..0x23 with data 0xA0..0xA3, then LW; fill_line word k = 0xA0+k; done at cycle 13.
- Stall: hold mem_ready=0 for 3 cycles during WB word 1 and for 2 cycles during FILL_REQ word 2 → address and write_data_int stable throughout the stall; no skipped or repeated beats; done at cycle 18.
- Unaligned miss_addr=0x2E (W=4) → addresses 0x2C..0x2F.
- miss_req pulsed during busy and during DONE → ignored; no second request sequence is issued.
- rst asserted in the FILL_CAP cycle of word 1 → busy=0 and mem_req=0 next cycle; no done; a new miss then completes normally from word 0.
